// File: rtl/vga_scan.sv
// VGA scan controller: issues pixel coordinates to a registered renderer and
// re-aligns sync/blank with the colour it returns before driving the DAC pins.
module vga_scan #(
  parameter int H_VALID = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VALID = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 4,
  parameter int PIX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pix_data,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        active,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VALID + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VALID + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VALID);
  localparam logic [9:0] V_VIS  = 10'(V_VALID);
  localparam logic [9:0] HS_BEG = 10'(H_VALID + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VALID + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VALID + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VALID + V_FP + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0]         div;
  logic               tick;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic               vis;
  logic               hs_raw;
  logic               vs_raw;
  logic [PIX_LAT-1:0] vis_pipe;
  logic [PIX_LAT-1:0] hs_pipe;
  logic [PIX_LAT-1:0] vs_pipe;

  assign tick   = !rst && (div == DIV_LAST);
  assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Coordinates are zeroed in blanking so the renderer never sees out-of-frame rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);
      if (tick) begin
        x <= vis ? h_cnt : 10'd0;
        y <= vis ? v_cnt[8:0] : 9'd0;
      end
    end
  end

  // Stage 0 loads alongside x/y, so the last stage lines up with the renderer's reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      vis_pipe  <= '0;
      hs_pipe   <= '1;
      vs_pipe   <= '1;
      active    <= 1'b0;
      hs        <= 1'b1;
      vs        <= 1'b1;
      {r, g, b} <= 12'h000;
    end else if (tick) begin
      vis_pipe[0] <= vis;
      hs_pipe[0]  <= hs_raw;
      vs_pipe[0]  <= vs_raw;
      for (int i = 1; i < PIX_LAT; i++) begin
        vis_pipe[i] <= vis_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
      active    <= vis_pipe[PIX_LAT-1];
      hs        <= hs_pipe[PIX_LAT-1];
      vs        <= vs_pipe[PIX_LAT-1];
      {r, g, b} <= vis_pipe[PIX_LAT-1] ? pix_data : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan: full-geometry instance at CLK_DIV=4/PIX_LAT=1 plus a
// short-frame instance at CLK_DIV=1/PIX_LAT=2 so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // dut0: default geometry, CLK_DIV=4, PIX_LAT=1
  logic [9:0]  x0;
  logic [8:0]  y0;
  logic        hs0, vs0, act0, fs0;
  logic [3:0]  r0, g0, b0;
  logic [11:0] rgb0, pix0, pix0_q;
  logic        force0 = 1'b0;
  assign rgb0 = {r0, g0, b0};
  always @(posedge clk) pix0_q <= {2'b00, x0};
  assign pix0 = force0 ? 12'hFFF : pix0_q;

  vga_scan dut0 (
    .clk(clk), .rst(rst), .pix_data(pix0), .x(x0), .y(y0), .hs(hs0), .vs(vs0),
    .r(r0), .g(g0), .b(b0), .active(act0), .frame_start(fs0)
  );

  // dut1: 13-line frame (6 visible, sync on lines 8..9), CLK_DIV=1, PIX_LAT=2
  logic [9:0]  x1;
  logic [8:0]  y1;
  logic        hs1, vs1, act1, fs1;
  logic [3:0]  r1, g1, b1;
  logic [11:0] rgb1, pix1, pix1_q;
  logic        force1 = 1'b0;
  assign rgb1 = {r1, g1, b1};
  always @(posedge clk) pix1_q <= {2'b00, x1};
  assign pix1 = force1 ? 12'hFFF : pix1_q;

  vga_scan #(.V_VALID(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(1), .PIX_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .pix_data(pix1), .x(x1), .y(y1), .hs(hs1), .vs(vs1),
    .r(r1), .g(g1), .b(b1), .active(act1), .frame_start(fs1)
  );

  // Expected request coordinates for dut1 (one tick per clk)
  int hm = 0, vm = 0;
  logic [9:0] xe1 = '0;
  logic [8:0] ye1 = '0;
  always @(posedge clk) begin
    if (rst) begin
      hm <= 0; vm <= 0; xe1 <= '0; ye1 <= '0;
    end else begin
      xe1 <= (hm < 640 && vm < 6) ? 10'(hm) : 10'd0;
      ye1 <= (hm < 640 && vm < 6) ? 9'(vm) : 9'd0;
      if (hm == 799) begin
        hm <= 0;
        vm <= (vm == 12) ? 0 : vm + 1;
      end else begin
        hm <= hm + 1;
      end
    end
  end

  // Edge timestamps and invariant counters, sampled on the falling clock edge
  int hs0_fall[$], hs0_rise[$], x0_639[$], run0_len[$];
  int hs1_fall[$], vs1_fall[$], vs1_rise[$], fs1_t[$], x1_639[$], run1_len[$];
  int run0 = 0, run1 = 0, viol0 = 0, viol1 = 0, xy_viol = 0;
  logic hs0_q = 1'b1, hs1_q = 1'b1, vs1_q = 1'b1, fs1_q = 1'b0;
  logic [9:0] x0_q = '0, x1_q = '0;

  always @(negedge clk) begin
    hs0_q <= hs0; hs1_q <= hs1; vs1_q <= vs1; fs1_q <= fs1;
    x0_q <= x0; x1_q <= x1;
    if (rst) begin
      hs0_fall.delete(); hs0_rise.delete(); x0_639.delete(); run0_len.delete();
      hs1_fall.delete(); vs1_fall.delete(); vs1_rise.delete(); fs1_t.delete();
      x1_639.delete(); run1_len.delete();
      run0 <= 0; run1 <= 0; viol0 <= 0; viol1 <= 0; xy_viol <= 0;
    end else begin
      if (hs0_q && !hs0) hs0_fall.push_back(cyc);
      if (!hs0_q && hs0) hs0_rise.push_back(cyc);
      if (hs1_q && !hs1) hs1_fall.push_back(cyc);
      if (vs1_q && !vs1) vs1_fall.push_back(cyc);
      if (!vs1_q && vs1) vs1_rise.push_back(cyc);
      if (fs1 && !fs1_q) fs1_t.push_back(cyc);
      if (x0 == 10'd639 && x0_q != 10'd639) x0_639.push_back(cyc);
      if (x1 == 10'd639 && x1_q != 10'd639) x1_639.push_back(cyc);
      if (act0) run0 <= run0 + 1;
      else if (run0 != 0) begin run0_len.push_back(run0); run0 <= 0; end
      if (act1) run1 <= run1 + 1;
      else if (run1 != 0) begin run1_len.push_back(run1); run1 <= 0; end
      if (!act0 && rgb0 != 12'h000) viol0 <= viol0 + 1;
      if (!act1 && rgb1 != 12'h000) viol1 <= viol1 + 1;
      if (x1 != xe1 || y1 != ye1) xy_viol <= xy_viol + 1;
    end
  end

  localparam int BUDGET = 20000;

  initial begin
    int k;
    int rel;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5000) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    chk("rst_rgb0", rgb0, 12'h000);
    chk("rst_hs0", hs0, 1);
    chk("rst_vs0", vs0, 1);
    chk("rst_x0", x0, 0);
    chk("rst_y0", y0, 0);
    chk("rst_act0", act0, 0);
    chk("rst_fs0", fs0, 0);
    chk("rst_rgb1", rgb1, 12'h000);
    chk("rst_hs1", hs1, 1);
    chk("rst_x1", x1, 0);

    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    chk("fs1_first_tick", fs1, 1);
    chk("x1_first", x1, 0);
    chk("y1_first", y1, 0);
    chk("fs0_not_yet", fs0, 0);
    @(negedge clk);
    chk("fs1_one_clk", fs1, 0);
    @(negedge clk);
    chk("fs0_not_yet3", fs0, 0);
    @(negedge clk);
    chk("fs0_first_tick", fs0, 1);
    chk("y0_first", y0, 0);
    @(negedge clk);
    chk("fs0_one_clk", fs0, 0);

    k = 0;
    while (!(x1 == 10'd10 && y1 == 9'd0) && k < BUDGET) begin @(negedge clk); k++; end
    chk("x1_10_seen", k < BUDGET, 1);
    @(negedge clk);
    chk("rgb1_prev_pix", rgb1, 12'h009);
    @(negedge clk);
    chk("rgb1_x10", rgb1, 12'h00A);
    force1 = 1'b1;

    k = 0;
    while (!(x0 == 10'd5 && y0 == 9'd0) && k < BUDGET) begin @(negedge clk); k++; end
    chk("x0_5_seen", k < BUDGET, 1);
    repeat (3) @(negedge clk);
    chk("rgb0_before_tick", rgb0, 12'h004);
    @(negedge clk);
    chk("rgb0_x5", rgb0, 12'h005);
    chk("act0_x5", act0, 1);

    k = 0;
    while (!(x0 == 10'd639) && k < BUDGET) begin @(negedge clk); k++; end
    chk("x0_639_seen", k < BUDGET, 1);
    repeat (4) @(negedge clk);
    chk("rgb0_x639", rgb0, 12'h27F);
    repeat (4) @(negedge clk);
    chk("rgb0_h640", rgb0, 12'h000);
    chk("act0_h640", act0, 0);
    chk("x0_h641", x0, 0);
    force0 = 1'b1;

    k = 0;
    while (hs0 && k < BUDGET) begin @(negedge clk); k++; end
    chk("hs0_low_seen", k < BUDGET, 1);
    chk("rgb0_hblank_fff", rgb0, 12'h000);
    chk("x0_hblank", x0, 0);
    chk("y0_hblank", y0, 0);

    k = 0;
    while (!(x0 == 10'd100 && y0 == 9'd1) && k < BUDGET) begin @(negedge clk); k++; end
    chk("x0_100_seen", k < BUDGET, 1);
    repeat (4) @(negedge clk);
    chk("rgb0_forced_vis", rgb0, 12'hFFF);

    k = 0;
    while (vs1 && k < BUDGET) begin @(negedge clk); k++; end
    chk("vs1_low_seen", k < BUDGET, 1);
    chk("rgb1_vblank_fff", rgb1, 12'h000);
    chk("act1_vblank", act1, 0);
    chk("x1_vblank", x1, 0);
    chk("y1_vblank", y1, 0);

    k = 0;
    while (!(x1 == 10'd100 && y1 == 9'd0) && k < BUDGET) begin @(negedge clk); k++; end
    chk("x1_100_seen", k < BUDGET, 1);
    repeat (2) @(negedge clk);
    chk("rgb1_forced_vis", rgb1, 12'hFFF);
    chk("act1_vis", act1, 1);

    while (cyc < rel + 17200) @(negedge clk);

    chk("hs0_period", (hs0_fall.size() >= 2) ? hs0_fall[1] - hs0_fall[0] : -1, 3200);
    chk("hs0_low_width", (hs0_fall.size() >= 1 && hs0_rise.size() >= 1) ?
        hs0_rise[0] - hs0_fall[0] : -1, 384);
    chk("hs0_after_x639", (hs0_fall.size() >= 1 && x0_639.size() >= 1) ?
        hs0_fall[0] - x0_639[0] : -1, 72);
    chk("act0_run", (run0_len.size() >= 1) ? run0_len[0] : -1, 2560);
    chk("hs1_period", (hs1_fall.size() >= 2) ? hs1_fall[1] - hs1_fall[0] : -1, 800);
    chk("hs1_after_x639", (hs1_fall.size() >= 1 && x1_639.size() >= 1) ?
        hs1_fall[0] - x1_639[0] : -1, 19);
    chk("act1_run", (run1_len.size() >= 1) ? run1_len[0] : -1, 640);
    chk("vs1_first_fall", (vs1_fall.size() >= 1) ? vs1_fall[0] - rel : -1, 6403);
    chk("vs1_period", (vs1_fall.size() >= 2) ? vs1_fall[1] - vs1_fall[0] : -1, 10400);
    chk("vs1_low_width", (vs1_fall.size() >= 1 && vs1_rise.size() >= 1) ?
        vs1_rise[0] - vs1_fall[0] : -1, 1600);
    chk("fs1_first", (fs1_t.size() >= 1) ? fs1_t[0] - rel : -1, 1);
    chk("fs1_period", (fs1_t.size() >= 2) ? fs1_t[1] - fs1_t[0] : -1, 10400);
    chk("blank_viol0", viol0, 0);
    chk("blank_viol1", viol1, 0);
    chk("xy1_model_viol", xy_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
